// File: rtl/game_sequencer.sv
// Simon game round sequencer: plays a growing LFSR colour sequence, scores player echoes, reports win/lose.
// Optional press timeout in WAIT_IN is enabled by defining GAME_TIMEOUT_EN.
module game_sequencer #(
    parameter int unsigned STEP_CYCLES    = 50_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000,
    parameter int unsigned RESULT_CYCLES  = 100_000_000
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic [5:0] i_seq_len,
    input  logic [1:0] i_speed,
    input  logic [3:0] i_btn,
    output logic       o_idle_en,
    output logic [3:0] o_led,
    output logic [5:0] o_round,
    output logic       o_busy,
    output logic       o_win,
    output logic       o_lose,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE      = 3'd1,
        S_SHOW_ON  = 3'd2,
        S_SHOW_OFF = 3'd3,
        S_WAIT_IN  = 3'd4,
        S_WIN      = 3'd5,
        S_LOSE     = 3'd6
    } state_t;

    // Timer is 24 bits unless the longest dwell needs more (the default parameters do).
    localparam longint unsigned SHOW_MAX = 64'(STEP_CYCLES) * 64'd4;
    localparam longint unsigned MAX_A    = (SHOW_MAX > 64'(TIMEOUT_CYCLES)) ? SHOW_MAX : 64'(TIMEOUT_CYCLES);
    localparam longint unsigned MAX_LOAD = (MAX_A > 64'(RESULT_CYCLES)) ? MAX_A : 64'(RESULT_CYCLES);
    localparam int TIMER_W = ($clog2(MAX_LOAD) > 24) ? $clog2(MAX_LOAD) : 24;

    localparam logic [TIMER_W-1:0] STEP_LOAD   = TIMER_W'(STEP_CYCLES - 32'd1);
    localparam logic [TIMER_W-1:0] RESULT_LOAD = TIMER_W'(RESULT_CYCLES - 32'd1);
`ifdef GAME_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 32'd1);
`endif
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [15:0]        seed_q, seed_d;
    logic [15:0]        cnt_q;
    logic               start_q;
    logic [5:0]         len_q, len_d;
    logic [1:0]         speed_q, speed_d;
    logic [5:0]         round_q, round_d;
    logic [5:0]         idx_q, idx_d;

    logic               idle_en_d, busy_d, win_d, lose_d;
    logic [3:0]         led_d;

    logic               start_pulse;
    logic               timer_zero;
    logic [3:0]         colour;
    logic [15:0]        lfsr_next;
    logic [33:0]        show_len;
    logic [TIMER_W-1:0] show_load;

    assign start_pulse = i_start & ~start_q;
    assign timer_zero  = (timer_q == '0);
    assign colour      = 4'b0001 << lfsr_q[1:0];
    assign lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign show_len    = 34'(STEP_CYCLES) * (34'd4 - 34'(speed_q));
    assign show_load   = TIMER_W'(show_len - 34'd1);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            lfsr_q    <= SEED_DEFAULT;
            seed_q    <= SEED_DEFAULT;
            cnt_q     <= 16'h0001;
            start_q   <= 1'b0;
            len_q     <= 6'd1;
            speed_q   <= 2'd0;
            round_q   <= 6'd0;
            idx_q     <= 6'd0;
            o_idle_en <= 1'b1;
            o_busy    <= 1'b0;
            o_win     <= 1'b0;
            o_lose    <= 1'b0;
            o_led     <= 4'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            cnt_q     <= cnt_q + 16'd1;
            start_q   <= i_start;
            len_q     <= len_d;
            speed_q   <= speed_d;
            round_q   <= round_d;
            idx_q     <= idx_d;
            o_idle_en <= idle_en_d;
            o_busy    <= busy_d;
            o_win     <= win_d;
            o_lose    <= lose_d;
            o_led     <= led_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        lfsr_d  = lfsr_q;
        seed_d  = seed_q;
        len_d   = len_q;
        speed_d = speed_q;
        round_d = round_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                if (start_pulse) begin
                    seed_d  = (cnt_q == 16'd0) ? SEED_DEFAULT : cnt_q;
                    speed_d = i_speed;
                    len_d   = (i_seq_len == 6'd0) ? 6'd1 : i_seq_len;
                    round_d = 6'd1;
                    timer_d = STEP_LOAD;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                lfsr_d = seed_q;
                idx_d  = 6'd0;
                if (timer_zero) begin
                    timer_d = show_load;
                    state_d = S_SHOW_ON;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_SHOW_ON: begin
                if (timer_zero) begin
                    lfsr_d  = lfsr_next;
                    idx_d   = idx_q + 6'd1;
                    timer_d = STEP_LOAD;
                    state_d = S_SHOW_OFF;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_SHOW_OFF: begin
                if (timer_zero) begin
                    if (idx_q < round_q) begin
                        timer_d = show_load;
                        state_d = S_SHOW_ON;
                    end else begin
                        // Replay the same sequence from the seed for scoring.
                        lfsr_d  = seed_q;
                        idx_d   = 6'd0;
`ifdef GAME_TIMEOUT_EN
                        timer_d = TIMEOUT_LOAD;
`endif
                        state_d = S_WAIT_IN;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_WAIT_IN: begin
                // A press on the expiry clock is scored before the timeout is considered.
                if (i_btn != 4'd0) begin
                    if (i_btn == colour) begin
                        lfsr_d = lfsr_next;
                        idx_d  = idx_q + 6'd1;
                        if ((idx_q + 6'd1) == round_q) begin
                            if (round_q == len_q) begin
                                timer_d = RESULT_LOAD;
                                state_d = S_WIN;
                            end else begin
                                round_d = round_q + 6'd1;
                                timer_d = STEP_LOAD;
                                state_d = S_PRE;
                            end
                        end else begin
`ifdef GAME_TIMEOUT_EN
                            timer_d = TIMEOUT_LOAD;
`endif
                        end
                    end else begin
                        timer_d = RESULT_LOAD;
                        state_d = S_LOSE;
                    end
                end else begin
`ifdef GAME_TIMEOUT_EN
                    if (timer_zero) begin
                        timer_d = RESULT_LOAD;
                        state_d = S_LOSE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
`endif
                end
            end
            S_WIN, S_LOSE: begin
                if (timer_zero) begin
                    round_d = 6'd0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                round_d = 6'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from next-state values so they change on the same edge as the state.
    always_comb begin
        idle_en_d = (state_d == S_IDLE);
        busy_d    = (state_d != S_IDLE);
        win_d     = (state_d == S_WIN);
        lose_d    = (state_d == S_LOSE);
        led_d     = 4'd0;
        if (state_d == S_SHOW_ON) begin
            led_d = 4'b0001 << lfsr_d[1:0];
        end else if (state_d == S_WIN) begin
            led_d = 4'hF;
        end
    end

    assign o_round     = round_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer with small timing parameters (STEP=4, TIMEOUT=20, RESULT=8).
module tb_game_sequencer;

    localparam int STEP    = 4;
    localparam int TIMEOUT = 20;
    localparam int RESULT  = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_start = 1'b0;
    logic [5:0] i_seq_len = 6'd0;
    logic [1:0] i_speed = 2'd0;
    logic [3:0] i_btn = 4'd0;
    logic       o_idle_en;
    logic [3:0] o_led;
    logic [5:0] o_round;
    logic       o_busy;
    logic       o_win;
    logic       o_lose;
    logic [2:0] o_dbg_state;

    int checks = 0;
    int failures = 0;

    logic [15:0] cnt_m;
    logic [15:0] seed_m;
    logic        noise_en = 1'b0;
    logic [3:0]  exp_q[$];

    game_sequencer #(
        .STEP_CYCLES(STEP),
        .TIMEOUT_CYCLES(TIMEOUT),
        .RESULT_CYCLES(RESULT)
    ) dut (
        .i_clk(i_clk),
        .i_reset_n(i_reset_n),
        .i_start(i_start),
        .i_seq_len(i_seq_len),
        .i_speed(i_speed),
        .i_btn(i_btn),
        .o_idle_en(o_idle_en),
        .o_led(o_led),
        .o_round(o_round),
        .o_busy(o_busy),
        .o_win(o_win),
        .o_lose(o_lose),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and reset-relative free-run counter model
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) cnt_m <= 16'h0001;
        else            cnt_m <= cnt_m + 16'd1;
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [3:0] colour_of(input logic [15:0] l);
        logic [3:0] c;
        c = 4'b0001 << l[1:0];
        return c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic noise_drive();
        if (noise_en) begin
            i_btn   = 4'($urandom_range(1, 15));
            i_start = ~i_start;
        end
    endtask

    // Driver tasks
    task automatic start_game(input logic [5:0] len, input logic [1:0] spd);
        i_seq_len = len;
        i_speed   = spd;
        i_start   = 1'b1;
        seed_m    = (cnt_m == 16'd0) ? 16'hACE1 : cnt_m;
        @(negedge i_clk);
        i_start = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_idle_en", o_idle_en, 0);
        check("start_round", o_round, 1);
        check("start_led", o_led, 0);
    endtask

    task automatic press(input logic [3:0] b);
        i_btn = b;
        @(negedge i_clk);
        i_btn = 4'd0;
    endtask

    task automatic wait_led_on(output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
            noise_drive();
        end while (o_led == 4'd0 && n < 100);
    endtask

    task automatic on_duration(output int n);
        n = 1;
        forever begin
            @(negedge i_clk);
            noise_drive();
            if (o_led == 4'd0 || n >= 100) break;
            n++;
        end
    endtask

    // Watch one round of playback against the scoreboard, end in WAIT_IN
    task automatic play_round(input int r, input int on_len);
        logic [15:0] l;
        int n;
        l = seed_m;
        for (int i = 0; i < r; i++) begin
            exp_q.push_back(colour_of(l));
            l = lfsr_step(l);
        end
        for (int i = 0; i < r; i++) begin
            wait_led_on(n);
            check("gap_len", n, STEP);
            check("led_colour", o_led, exp_q.pop_front());
            on_duration(n);
            check("on_len", n, on_len);
        end
        noise_en = 1'b0;
        i_btn    = 4'd0;
        i_start  = 1'b0;
        repeat (STEP) @(negedge i_clk);
        check("wait_state", o_dbg_state, ST_WAIT);
    endtask

    task automatic enter_presses(input int r);
        logic [15:0] l;
        l = seed_m;
        for (int i = 0; i < r; i++) begin
            press(colour_of(l));
            l = lfsr_step(l);
            if (i < r - 1) begin
                check("mid_press_state", o_dbg_state, ST_WAIT);
                check("mid_press_round", o_round, r);
            end
        end
    endtask

    task automatic finish_result(input logic want_win);
        int n;
        n = 1;
        forever begin
            @(negedge i_clk);
            if (!(want_win ? o_win : o_lose) || n >= 100) break;
            n++;
        end
        check(want_win ? "win_len" : "lose_len", n, RESULT);
        check("end_idle_en", o_idle_en, 1);
        check("end_round", o_round, 0);
        check("end_busy", o_busy, 0);
        check("end_led", o_led, 0);
        check("end_flags", {o_win, o_lose}, 0);
    endtask

    typedef struct {
        logic [5:0] len;
        logic [1:0] spd;
        int         rounds;
        int         on_len;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [3:0] c;
        int n;

        vecs[0] = '{len: 6'd2, spd: 2'd3, rounds: 2, on_len: 4};
        vecs[1] = '{len: 6'd0, spd: 2'd0, rounds: 1, on_len: 16};
        vecs[2] = '{len: 6'd3, spd: 2'd2, rounds: 3, on_len: 8};
        vecs[3] = '{len: 6'd1, spd: 2'd1, rounds: 1, on_len: 12};

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_idle_en", o_idle_en, 1);
        check("rst_outputs", {o_led, o_round, o_busy, o_win, o_lose}, 0);
        check("rst_state", o_dbg_state, ST_IDLE);
        i_reset_n = 1'b1;
        repeat (9) @(negedge i_clk);

        // Full winning games; first game carries ignored presses / start edges in round 1
        for (int v = 0; v < 4; v++) begin
            start_game(vecs[v].len, vecs[v].spd);
            noise_en = (v == 0);
            for (int r = 1; r <= vecs[v].rounds; r++) begin
                play_round(r, vecs[v].on_len);
                check("pre_press_round", o_round, r);
                enter_presses(r);
                if (r < vecs[v].rounds) begin
                    check("next_round", o_round, r + 1);
                    check("next_pre", o_dbg_state, ST_PRE);
                    check("next_led", o_led, 0);
                end else begin
                    check("win_flag", {o_win, o_lose, o_busy}, 3'b101);
                    check("win_led", o_led, 4'hF);
                    check("win_round", o_round, vecs[v].rounds);
                end
            end
            finish_result(1'b1);
            repeat (3) @(negedge i_clk);
        end

        // Wrong single colour in round 1
        start_game(6'd2, 2'd3);
        play_round(1, 4);
        c = colour_of(seed_m);
        press({c[2:0], c[3]});
        check("wrong_lose", {o_win, o_lose, o_busy}, 3'b011);
        check("wrong_led", o_led, 0);
        check("wrong_round", o_round, 1);
        finish_result(1'b0);
        repeat (2) @(negedge i_clk);

        // Multi-hot press
        start_game(6'd2, 2'd3);
        play_round(1, 4);
        press(4'b0011);
        check("multi_lose", o_lose, 1);
        check("multi_led", o_led, 0);
        finish_result(1'b0);
        repeat (2) @(negedge i_clk);

        // No press in WAIT_IN
        start_game(6'd1, 2'd3);
        play_round(1, 4);
`ifdef GAME_TIMEOUT_EN
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_lose && n < 100);
        check("timeout_len", n, TIMEOUT);
        check("timeout_lose", o_lose, 1);
        finish_result(1'b0);
`else
        repeat (1000) @(negedge i_clk);
        check("nowait_state", o_dbg_state, ST_WAIT);
        check("nowait_flags", {o_busy, o_lose, o_win}, 3'b100);
        press(colour_of(seed_m));
        check("nowait_win", o_win, 1);
        finish_result(1'b1);
`endif
        repeat (2) @(negedge i_clk);

        // Asynchronous reset during SHOW_ON
        start_game(6'd2, 2'd3);
        wait_led_on(n);
        check("rst_mid_led_on", o_led, colour_of(seed_m));
        #2 i_reset_n = 1'b0;
        #1;
        check("rst_mid_led", o_led, 0);
        check("rst_mid_idle_en", o_idle_en, 1);
        check("rst_mid_round", o_round, 0);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_state", o_dbg_state, ST_IDLE);
        @(negedge i_clk);
        i_reset_n = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_after_state", o_dbg_state, ST_IDLE);
        check("rst_after_idle_en", o_idle_en, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
